// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver.
// Frame states plus the mid-start and end-of-bit tick thresholds.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int START_MID = OVERSAMPLE_DEFAULT / 2 - 1;
  localparam int BIT_END   = OVERSAMPLE_DEFAULT - 1;

  function automatic int start_mid(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int bit_end(input int os);
    return os - 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: oversample strobe and serial line in,
// received word, status pulses and busy flag out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tick;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output tick,
    output rx,
    input  data,
    input  data_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  tick,
    input  rx,
    output data,
    output data_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RST_VAL so an idle-high line stays quiet.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver, LSB first, mid-bit sampling.
// Emits one-cycle data_valid / frame_err pulses; BREAK absorbs a held-low line.
import uart_pkg::*;

module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_MID = SW'(start_mid(OVERSAMPLE));
  localparam logic [SW-1:0] S_END = SW'(bit_end(OVERSAMPLE));
  localparam logic [NW-1:0] N_END = NW'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 fe_q, fe_d;
  logic                 rxs;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.rx),
    .q  (rxs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick_en()) begin
          if (s_q == S_MID) begin
            // Still low at mid-start: a real start bit, not a glitch
            if (!rxs) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick_en()) begin
          if (s_q == S_END) begin
            s_d  = '0;
            sh_d = {rxs, sh_q[DATA_BITS-1:1]};
            if (n_q == N_END) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick_en()) begin
          if (s_q == S_END) begin
            if (rxs) begin
              data_d  = sh_q;
              dv_d    = 1'b1;
              state_d = IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = BREAK;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.data       = data_q;
    bus.data_valid = dv_q;
    bus.frame_err  = fe_q;
  end

  function automatic logic tick_en();
    return bus.tick;
  endfunction

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: frames are queued as expected
// results when sent, a monitor pops and compares on each output pulse.
module tb_uart_rx;

  typedef struct {
    bit         err;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if #(.DATA_BITS(8)) u ();

  uart_rx #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u.slave)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         tph = 0;
  logic [7:0] model_data = 8'h00;
  exp_t       q[$];
  int         dv_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    tph    = (tph + 1) % 4;
    u.tick = (tph == 0);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (u.data_valid === 1'b1 || u.frame_err === 1'b1)) begin
      chk("pulse_exclusive", int'(u.data_valid & u.frame_err), 0);
      if (u.data_valid === 1'b1) begin
        dv_t.push_back(cyc);
        chk("busy_at_valid", int'(u.busy), 0);
      end
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind_err", int'(u.frame_err), int'(e.err));
        if (e.err) begin
          chk("data_kept_on_err", int'(u.data), int'(model_data));
        end else begin
          chk("rx_data", int'(u.data), int'(e.d));
          model_data = e.d;
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    u.rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit stop_ok,
                      input int rst_at);
    exp_t e;
    if (rst_at < 0) begin
      e.err = !stop_ok;
      e.d   = d;
      q.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_at) begin
        u.rx = d[i];
        repeat (32) @(negedge clk);
        rst        = 1'b1;
        model_data = 8'h00;
        @(negedge clk);
        chk("busy_after_rst", int'(u.busy), 0);
        chk("data_after_rst", int'(u.data), 0);
        chk("valid_after_rst", int'(u.data_valid), 0);
        rst  = 1'b0;
        u.rx = 1'b1;
        repeat (64 * 8) @(negedge clk);
        return;
      end
      drive_bit(d[i]);
    end
    drive_bit(stop_ok);
    if (!stop_ok) begin
      repeat (160) @(negedge clk);
      u.rx = 1'b1;
      repeat (64) @(negedge clk);
    end
  endtask

  initial begin
    int         t0;
    int         n0;
    logic [7:0] rd;
    bit         ok;
    u.rx = 1'b1;
    rst  = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data", int'(u.data), 0);
    chk("rst_valid", int'(u.data_valid), 0);
    chk("rst_ferr", int'(u.frame_err), 0);
    chk("rst_busy", int'(u.busy), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single good frame with latency measurement
    n0 = dv_t.size();
    t0 = cyc;
    send(8'h55, 1'b1, -1);
    repeat (40) @(negedge clk);
    chk("valid_count_55", dv_t.size() - n0, 1);
    if (dv_t.size() > n0) chk_rng("latency_55", dv_t[n0] - t0, 608, 611);

    // Start-bit glitch of 3 ticks
    u.rx = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_in_glitch", int'(u.busy), 1);
    repeat (4) @(negedge clk);
    u.rx = 1'b1;
    repeat (36) @(negedge clk);
    chk("busy_after_glitch", int'(u.busy), 0);
    chk("data_after_glitch", int'(u.data), 'h55);
    repeat (100) @(negedge clk);

    // Framing error followed by a held-low line
    send(8'hA3, 1'b0, -1);
    repeat (100) @(negedge clk);
    chk("data_after_ferr", int'(u.data), 'h55);
    chk("busy_after_break", int'(u.busy), 0);

    // Back-to-back frames
    n0 = dv_t.size();
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    repeat (40) @(negedge clk);
    chk("valid_count_b2b", dv_t.size() - n0, 2);
    if (dv_t.size() >= n0 + 2)
      chk("b2b_spacing", dv_t[n0+1] - dv_t[n0], 640);

    // Reset during data bit 4, then a clean frame
    send(8'h12, 1'b1, 4);
    repeat (100) @(negedge clk);
    send(8'h3C, 1'b1, -1);
    repeat (40) @(negedge clk);
    chk("data_3c", int'(u.data), 'h3C);

    for (int k = 0; k < 14; k++) begin
      rd = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send(rd, ok, -1);
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end

    repeat (200) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("final_busy", int'(u.busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampling UART receiver; consumes the one-cycle `tick` strobe produced by the baud rate generator (one pulse per 1/16 bit period).
- Deserialises 8N1 frames, LSB first, from the asynchronous `rx` pin.
- Presents each received byte with a one-cycle valid pulse and flags framing errors.
- Sits beside the baud rate generator in top_communication, feeding the command/data path of the microprocessor.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- OVERSAMPLE, 16, ticks per bit period; must match the baud rate generator's oversampling factor.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- tick  input  1  oversample enable strobe, one clk cycle wide.
- rx  input  1  asynchronous serial line, idle high.
- data  output  DATA_BITS  last correctly received word.
- data_valid  output  1  one-cycle pulse when `data` is updated.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset and clock: one clock (clk); reset rst is synchronous, active-high.
- Reset values: data=0, data_valid=0, frame_err=0, busy=0, state=IDLE, tick counter s=0, bit counter n=0, shift register=0, synchronizer flops=1.
- Reset mid-frame: abort the frame, return to IDLE, emit no pulse.
- Input synchronisation: rx passes through a 2-flop synchronizer reset to 1; all decisions use the synchronised `rxs`.
- Counters: s and n advance only on cycles where tick=1; on all other cycles they hold. s is $clog2(OVERSAMPLE) bits wide; n is $clog2(DATA_BITS) bits wide.
- IDLE: when rxs==0 (checked every clk), go to START with s=0.
- START: on tick, if s==OVERSAMPLE/2-1, check rxs.
  - rxs==0: go to DATA with s=0, n=0.
  - rxs==1: glitch; go to IDLE.
  - Otherwise s++.
- DATA: on tick, if s==OVERSAMPLE-1:
  - set s=0 and shift rxs into the MSB of the shift register (right shift, so LSB-first arrival ends LSB-aligned);
  - if n==DATA_BITS-1 go to STOP, else n++.
  - Otherwise s++.
- STOP: on tick, if s==OVERSAMPLE-1, sample rxs.
  - rxs==1: register data <= shift register, pulse data_valid, go to IDLE.
  - rxs==0: pulse frame_err, leave data unchanged, go to BREAK.
- BREAK: hold until rxs==1, then go to IDLE. This keeps a break condition from retriggering a frame.
- Output timing:
  - data_valid and frame_err are registered and high for exactly one clk, in the cycle after the qualifying tick. They are never high together.
  - Sampling lands at mid-bit. Returning to IDLE at mid-stop lets a back-to-back start edge half a bit later be caught.
- Simultaneous events:
  - rst dominates tick.
  - A start edge arriving in the same cycle as the STOP exit is detected on the next clk (≤2 clk skew, tolerated).
- Latency from the first start-bit low at the pin to the data_valid pulse:
  - 2 clk synchroniser;
  - then (OVERSAMPLE/2) + (DATA_BITS+1)·OVERSAMPLE ticks;
  - then 1 clk.

Decomposition:
- Package uart_pkg holds:
  - the typedef enum for state (IDLE, START, DATA, STOP, BREAK);
  - localparam OVERSAMPLE_DEFAULT=16;
  - the START_MID = OVERSAMPLE/2-1 and BIT_END = OVERSAMPLE-1 constants.
- One sub-module: sync_2ff (parameterised reset value, here 1) for the rx synchronizer.

Test Plan:
- Bench setup: the bench drives tick every 4 clk, so one bit = 64 clk.
- Frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1) -> exactly one data_valid pulse, data=0x55, frame_err never high, busy falls in the same cycle.
- rx low for 3 ticks (12 clk), then high -> no data_valid or frame_err; busy returns to 0 by START_MID; data unchanged.
- Frame 0xA3 with the stop bit low, line held low for 40 ticks, then high -> one frame_err pulse, no data_valid, data still 0x55, no further pulses until the line is high and a new start bit arrives.
- Back-to-back frames 0x00 then 0xFF with stop bit → start bit directly adjacent -> two data_valid pulses 10 bit times apart, data=0x00 then 0xFF.
- rst asserted for 1 clk during data bit 4 of frame 0x12 -> busy=0 next cycle, no pulse; following frame 0x3C -> data_valid, data=0x3C.
